// File: rtl/riscv_aes_pkg.sv
// Shared AES-128 constants and helpers: S-box, round constants, xtime, FSM states.
// Used by riscv_aes_round and riscv_aes_core (optional macro RISCV_AES_BUSY_ERR_EN lives in the core).
`timescale 1ns/1ps
package riscv_aes_pkg;

  localparam int AES_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round numbers outside 1..10 (idle counter values) map to a zero constant.
  function automatic logic [7:0] rcon_of(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    if (round >= 4'd1 && round <= 4'd10) r = RCON[int'(round) - 1];
    return r;
  endfunction

endpackage

// File: rtl/riscv_aes_round.sv
// One AES-128 encryption round plus the matching key-schedule step, purely combinational.
// Bytes are numbered FIPS-197 style: byte 0 sits in bits [127:120].
`timescale 1ns/1ps
module riscv_aes_round
  import riscv_aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last_round,
  input  logic [7:0]   rcon,
  output logic [127:0] next_state,
  output logic [127:0] next_key
);

  logic [7:0]  sb [16];
  logic [7:0]  sr [16];
  logic [7:0]  mc [16];
  logic [31:0] rot;
  logic [31:0] sub_w;
  logic [31:0] w0, w1, w2, w3;

  assign rot   = {round_key[23:0], round_key[31:24]};
  assign sub_w = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]} ^ {rcon, 24'h0};
  assign w0    = round_key[127:96] ^ sub_w;
  assign w1    = round_key[95:64]  ^ w0;
  assign w2    = round_key[63:32]  ^ w1;
  assign w3    = round_key[31:0]   ^ w2;
  assign next_key = {w0, w1, w2, w3};

  // State byte (row r, column c) is byte index r + 4*c.
  always_comb begin
    next_state = '0;
    for (int i = 0; i < 16; i++) sb[i] = SBOX[state[127-8*i -: 8]];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r + 4*((c+r)%4)];
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++)
      next_state[127-8*i -: 8] = (last_round ? sr[i] : mc[i]) ^ next_key[127-8*i -: 8];
  end

endmodule

// File: rtl/riscv_aes_core.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key expansion.
// Optional macro RISCV_AES_BUSY_ERR_EN enables the sticky start-while-busy flag on err_o.
`timescale 1ns/1ps
module riscv_aes_core
  import riscv_aes_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  input  logic [DATA_WIDTH-1:0] data_c_i,
  input  logic [DATA_WIDTH-1:0] data_d_i,
  input  logic [DATA_WIDTH-1:0] key_a_i,
  input  logic [DATA_WIDTH-1:0] key_b_i,
  input  logic [DATA_WIDTH-1:0] key_c_i,
  input  logic [DATA_WIDTH-1:0] key_d_i,
  output logic [DATA_WIDTH-1:0] result_a_o,
  output logic [DATA_WIDTH-1:0] result_b_o,
  output logic [DATA_WIDTH-1:0] result_c_o,
  output logic [DATA_WIDTH-1:0] result_d_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ROUND = ST_ROUND;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]   fsm;
  logic [3:0]   cnt;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [127:0] result_q;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic         accept;
  logic         last;

  assign accept = start_i && (fsm == IDLE || fsm == DONE);
  assign last   = (cnt == 4'(AES_ROUNDS));

  riscv_aes_round u_round (
    .state      (state_q),
    .round_key  (key_q),
    .last_round (last),
    .rcon       (rcon_of(cnt)),
    .next_state (rnd_state),
    .next_key   (rnd_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= IDLE;
      cnt      <= 4'd0;
      state_q  <= '0;
      key_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      state_q <= {data_a_i, data_b_i, data_c_i, data_d_i} ^ {key_a_i, key_b_i, key_c_i, key_d_i};
      key_q   <= {key_a_i, key_b_i, key_c_i, key_d_i};
      cnt     <= 4'd1;
      fsm     <= ROUND;
    end else if (fsm == ROUND) begin
      state_q <= rnd_state;
      key_q   <= rnd_key;
      cnt     <= cnt + 4'd1;
      if (last) begin
        result_q <= rnd_state;
        fsm      <= DONE;
      end
    end else if (fsm == DONE) begin
      fsm <= IDLE;
    end
  end

  assign result_a_o = result_q[127:96];
  assign result_b_o = result_q[95:64];
  assign result_c_o = result_q[63:32];
  assign result_d_o = result_q[31:0];
  assign busy_o     = (fsm == ROUND);
  assign done_o     = (fsm == DONE);

`ifdef RISCV_AES_BUSY_ERR_EN
  logic err_q;

  // A start seen during ROUND wins over clearing; an accepted start clears the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        err_q <= 1'b0;
    else if (fsm == ROUND && start_i)  err_q <= 1'b1;
    else if (accept)                   err_q <= 1'b0;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_aes_core.sv
// Self-checking bench for riscv_aes_core: known-answer vectors plus random blocks against an AES model.
// The model derives its S-box from GF(2^8) inversion and the affine map.
`timescale 1ns/1ps
module tb_riscv_aes_core;

`ifdef RISCV_AES_BUSY_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] data_a, data_b, data_c, data_d;
  logic [31:0] key_a, key_b, key_c, key_d;
  logic [31:0] result_a, result_b, result_c, result_d;
  logic        busy, done, err;
  logic [127:0] res;

  int checks = 0;
  int failures = 0;
  logic [7:0] sbox_m [256];

  always #5 clk = ~clk;

  riscv_aes_core #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .data_a_i   (data_a),
    .data_b_i   (data_b),
    .data_c_i   (data_c),
    .data_d_i   (data_d),
    .key_a_i    (key_a),
    .key_b_i    (key_b),
    .key_c_i    (key_c),
    .key_d_i    (key_d),
    .result_a_o (result_a),
    .result_b_o (result_b),
    .result_c_o (result_c),
    .result_d_o (result_d),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  assign res = {result_a, result_b, result_c, result_d};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] out;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr + 4*((c+rr)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r != 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic set_inputs(input logic [127:0] d, input logic [127:0] k);
    {data_a, data_b, data_c, data_d} = d;
    {key_a, key_b, key_c, key_d} = k;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Waits (bounded) for done after the accepting edge; returns edges counted.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [127:0] d, input logic [127:0] k,
                        input logic [127:0] exp);
    int n;
    @(posedge clk); #1;
    set_inputs(d, k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 128'(busy), 128'(1'b1));
    wait_done(n);
    check({tag, "_lat"}, 128'(n), 128'(10));
    check({tag, "_res"}, res, exp);
    check({tag, "_busy_end"}, 128'(busy), 128'(1'b0));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 128'(done), 128'(1'b0));
  endtask

  localparam logic [127:0] C1_D = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] C1_K = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] C1_R = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] B_D  = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] B_K  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] B_R  = 128'h3925841d_02dc09fb_dc118597_196a0b32;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] d0, k0, d1, k1, exp0, exp1;
    int n, seen;
    rst_n = 1'b0;
    start = 1'b0;
    set_inputs('0, '0);
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    check("rst_res",  res, '0);
    check("rst_busy", 128'(busy), '0);
    check("rst_done", 128'(done), '0);
    check("rst_err",  128'(err), '0);
    rst_n = 1'b1;

    run_op("c1", C1_D, C1_K, C1_R);
    run_op("appb", B_D, B_K, B_R);
    for (int i = 0; i < 4; i++) begin
      d0 = rand128(); k0 = rand128();
      run_op($sformatf("rand%0d", i), d0, k0, aes_ref(d0, k0));
    end

    // Inputs change and start pulses while rounds are running.
    d0 = rand128(); k0 = rand128(); exp0 = aes_ref(d0, k0);
    @(posedge clk); #1;
    set_inputs(d0, k0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    set_inputs(~d0, rand128());
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("dist_lat", 128'(n + 4), 128'(10));
    check("dist_res", res, exp0);
    check("dist_err", 128'(err), 128'(ERR_EXP));
    @(posedge clk); #1;
    check("dist_err_sticky", 128'(err), 128'(ERR_EXP));
    check("dist_done_pulse", 128'(done), '0);

    // start held high across two operations.
    d0 = rand128(); k0 = rand128(); exp0 = aes_ref(d0, k0);
    d1 = rand128(); k1 = rand128(); exp1 = aes_ref(d1, k1);
    @(posedge clk); #1;
    set_inputs(d0, k0);
    start = 1'b1;
    @(posedge clk); #1;
    set_inputs(d1, k1);
    wait_done(n);
    check("b2b_lat1", 128'(n), 128'(10));
    check("b2b_res1", res, exp0);
    check("b2b_err1", 128'(err), 128'(ERR_EXP));
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_gap", 128'(done), '0);
    check("b2b_busy_again", 128'(busy), 128'(1'b1));
    check("b2b_res_hold", res, exp0);
    wait_done(n);
    check("b2b_spacing", 128'(n + 1), 128'(11));
    check("b2b_res2", res, exp1);
    check("b2b_err_cleared", 128'(err), '0);
    @(posedge clk); #1;

    // Asynchronous reset part-way through the rounds.
    d0 = rand128(); k0 = rand128();
    set_inputs(d0, k0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_res",  res, '0);
    check("mid_rst_busy", 128'(busy), '0);
    check("mid_rst_done", 128'(done), '0);
    check("mid_rst_err",  128'(err), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("mid_rst_no_done", 128'(seen), '0);
    check("mid_rst_res_zero", res, '0);
    run_op("c1_after_rst", C1_D, C1_K, C1_R);

    // Idle hold: nothing changes without a start.
    set_inputs(rand128(), rand128());
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check("hold_res",  res, C1_R);
      check("hold_done", 128'(done), '0);
      check("hold_busy", 128'(busy), '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
